rbi_mmu_acl_cache: RTL
======================

Name: rbi_mmu_acl_cache

Overview:
- 4-entry ACL cache directly upstream of the MMU access checker; drives its aclEntryA..D inputs.
- Holds ACL entries in MRU order (A = most recent); promotes hits and shifts in new entries.
- On a lookup miss for an ACL-enabled page, requests the missing entry from the ring-bus ACL walker over a req/ack handshake.
- Also accepts explicit software loads (LDACL) and flushes.

Parameters:
- ACL_W, 48, entry width. Layout: [15:0] TLB VUGID key, [31:16] KRR key, [43:32] access mode, [47:44] reserved (stored, passed through).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- regInHold  in  1  pipeline hold; freezes lookup-driven actions
- regInKRR  in  64  keyring register, four 16-bit keys
- tlbInAcc  in  36  TLB access word; [31:16] VUGID, [5] ACL-enable
- lookupValid  in  1  tlbInAcc is valid this cycle
- ldaclValid  in  1  software insert strobe
- ldaclEntry  in  48  entry to insert
- aclFlush  in  1  invalidate all entries
- aclMissReq  out  1  miss request to walker
- aclMissVugid  out  16  VUGID being requested
- aclMissKrr  out  64  KRR snapshot for request
- aclMissAck  in  1  walker response strobe
- aclMissNone  in  1  with ack: no ACL exists
- aclMissEntry  in  48  with ack (when !aclMissNone): fetched entry
- aclEntryA..aclEntryD  out  48 each  entries to checker; 0 when slot invalid
- aclBusy  out  1  miss outstanding

Behaviour:
- Storage: 4 × (valid, 48-bit entry). Outputs are registered contents gated by the valid bit. Reset: all valid=0, all outputs 0, aclMissReq=0, aclBusy=0, state IDLE, suppress register cleared.
- Hit (combinational): slot valid && entry[15:0]==tlbInAcc[31:16] && entry[31:16] equals any of the four KRR keys. Lowest index wins.
- Promote: lookupValid && !regInHold && hit on slot k>0 → next cycle slot A=k; slots above k shift down one; slots below k unchanged. Hit on A: no change.
- Insert (ldacl or fill): if an entry with the same [31:0] exists, remove it and close the gap. New entry goes to A; others shift down; D is dropped when all four are valid.
- Priority per cycle: flush > insert (fill over ldacl; the ldacl is dropped and the walker fill is taken) > promote. Insert and promote in the same cycle: only the insert is applied.
- Flush: all valid=0 next cycle; suppress register cleared; any outstanding miss is abandoned (state→IDLE, aclMissReq→0). A late ack after that is ignored.
- FSM IDLE:
  - Enter MISS when lookupValid && tlbInAcc[5] && !hit && !regInHold && !(suppress matches VUGID+KRR).
  - On entry, register VUGID/KRR into aclMissVugid/aclMissKrr; aclMissReq=1 and aclBusy=1 from the next cycle.
- FSM MISS:
  - aclMissReq held high and request fields stable until ack; ack is sampled only in MISS.
  - On ack with !none: insert aclMissEntry (visible on aclEntryA the cycle after ack).
  - On ack with none: load suppress register with the request key; no insert.
  - Either case: →IDLE, req/busy=0 the cycle after ack.
- Suppress register is cleared by any insert or flush.
- regInHold does not stall the FSM or inserts; it only blocks promote and miss launch.
- Reset mid-MISS: immediate return to reset state.

Optional Feature:
- Macro: RBI_ACLCACHE_KRRFLUSH_EN.
- Defined: an internal register holds the previous KRR. If regInKRR differs from it in any cycle (reset excluded), perform an implicit flush the next cycle, with flush semantics including miss abandonment.
- Undefined: KRR changes have no effect on contents; a flush occurs only via aclFlush.

Test Plan:
- Reset, then 4 ldacl inserts with keys V=1..4, KRR key 0x0401 → D=V1, C=V2, B=V3, A=V4; 5th insert V=5 → V1 evicted, A=V5.
- Lookup VUGID=2 with regInKRR[15:0]=0x0401, no hold → next cycle A=V2, B=V5, C=V4, D=V3; repeat with regInHold=1 → order unchanged.
- Lookup VUGID=9 with tlbInAcc[5]=1 (miss) → aclMissReq=1, aclMissVugid=9 next cycle, held 5 cycles; ack with entry V9 → aclEntryA=V9 the cycle after, req=0.
- Miss, then ack with aclMissNone=1 → no insert; same lookup repeated → no new request; ldacl any → same lookup now re-requests.
- Flush during MISS plus simultaneous ldacl → all outputs 0, req=0, ldacl dropped; late ack ignored.
- With KRRFLUSH_EN: fill 2 entries, change regInKRR → all outputs 0 after two cycles (one cycle to detect, one to flush); without the macro → entries retained.

Source files
------------

// File: rtl/rbi_mmu_acl_cache.sv
// 4-entry MRU ACL cache feeding the MMU access checker; misses are fetched from the ring-bus ACL walker.
// Optional RBI_ACLCACHE_KRRFLUSH_EN: any keyring change triggers an implicit flush one cycle later.
module rbi_mmu_acl_cache #(
  parameter int ACL_W = 48
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             regInHold,
  input  logic [63:0]      regInKRR,
  input  logic [35:0]      tlbInAcc,
  input  logic             lookupValid,
  input  logic             ldaclValid,
  input  logic [ACL_W-1:0] ldaclEntry,
  input  logic             aclFlush,
  output logic             aclMissReq,
  output logic [15:0]      aclMissVugid,
  output logic [63:0]      aclMissKrr,
  input  logic             aclMissAck,
  input  logic             aclMissNone,
  input  logic [ACL_W-1:0] aclMissEntry,
  output logic [ACL_W-1:0] aclEntryA,
  output logic [ACL_W-1:0] aclEntryB,
  output logic [ACL_W-1:0] aclEntryC,
  output logic [ACL_W-1:0] aclEntryD,
  output logic             aclBusy
);
  localparam int SLOTS = 4;

  typedef enum logic {S_IDLE = 1'b0, S_MISS = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [SLOTS-1:0]              vld_q, vld_d;
  logic [SLOTS-1:0][ACL_W-1:0]   ent_q, ent_d;
  logic [15:0]                   vugid_q, vugid_d;
  logic [63:0]                   krr_q, krr_d;
  logic                          supp_q, supp_d;
  logic [15:0]                   supp_vugid_q, supp_vugid_d;
  logic [63:0]                   supp_krr_q, supp_krr_d;

  logic [15:0]      lk_vugid;
  logic [SLOTS-1:0] slot_hit;
  logic             any_hit;
  logic [1:0]       hit_idx;
  logic             flush, fill, ins_vld, supp_hit, launch;
  logic [ACL_W-1:0] ins_ent;
  logic [2:0]       n;
  logic             unused_acc;

  assign lk_vugid   = tlbInAcc[31:16];
  assign unused_acc = ^{tlbInAcc[35:32], tlbInAcc[15:6], tlbInAcc[4:0]};

  for (genvar g = 0; g < SLOTS; g++) begin : g_hit
    assign slot_hit[g] = vld_q[g] && (ent_q[g][15:0] == lk_vugid) &&
                         ((ent_q[g][31:16] == regInKRR[15:0])  || (ent_q[g][31:16] == regInKRR[31:16]) ||
                          (ent_q[g][31:16] == regInKRR[47:32]) || (ent_q[g][31:16] == regInKRR[63:48]));
  end
  assign any_hit = |slot_hit;

  always_comb begin
    hit_idx = 2'd0;
    for (int i = SLOTS-1; i >= 0; i--) if (slot_hit[i]) hit_idx = 2'(i);
  end

`ifdef RBI_ACLCACHE_KRRFLUSH_EN
  logic [63:0] krr_prev_q;
  logic        kflush_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      krr_prev_q <= regInKRR;
      kflush_q   <= 1'b0;
    end else begin
      krr_prev_q <= regInKRR;
      kflush_q   <= (regInKRR != krr_prev_q);
    end
  end
  assign flush = aclFlush | kflush_q;
`else
  assign flush = aclFlush;
`endif

  assign fill     = (state_q == S_MISS) && aclMissAck && !aclMissNone;
  assign ins_vld  = fill | ldaclValid;
  assign ins_ent  = fill ? aclMissEntry : ldaclEntry;
  assign supp_hit = supp_q && (supp_vugid_q == lk_vugid) && (supp_krr_q == regInKRR);
  assign launch   = (state_q == S_IDLE) && lookupValid && tlbInAcc[5] && !any_hit &&
                    !regInHold && !supp_hit && !flush;

  // Storage: insert rebuilds the list as {new, survivors minus duplicate}, compacted and truncated.
  always_comb begin
    vld_d = vld_q;
    ent_d = ent_q;
    n     = 3'd1;
    if (flush) begin
      vld_d = '0;
    end else if (ins_vld) begin
      vld_d    = '0;
      vld_d[0] = 1'b1;
      ent_d[0] = ins_ent;
      for (int i = 0; i < SLOTS; i++) begin
        if (vld_q[i] && (ent_q[i][31:0] != ins_ent[31:0]) && (n < 3'd4)) begin
          vld_d[n[1:0]] = 1'b1;
          ent_d[n[1:0]] = ent_q[i];
          n = n + 3'd1;
        end
      end
    end else if (lookupValid && !regInHold && any_hit && (hit_idx != 2'd0)) begin
      ent_d[0] = ent_q[hit_idx];
      vld_d[0] = 1'b1;
      for (int i = 1; i < SLOTS; i++) begin
        if (i <= int'(hit_idx)) begin
          ent_d[i] = ent_q[i-1];
          vld_d[i] = vld_q[i-1];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    vugid_d      = vugid_q;
    krr_d        = krr_q;
    supp_d       = supp_q;
    supp_vugid_d = supp_vugid_q;
    supp_krr_d   = supp_krr_q;
    if (ins_vld) supp_d = 1'b0;
    case (state_q)
      S_IDLE: if (launch) begin
        state_d = S_MISS;
        vugid_d = lk_vugid;
        krr_d   = regInKRR;
      end
      S_MISS: if (aclMissAck) begin
        state_d = S_IDLE;
        // A "no ACL" answer is remembered so the same lookup does not re-request.
        if (aclMissNone) begin
          supp_d       = 1'b1;
          supp_vugid_d = vugid_q;
          supp_krr_d   = krr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      supp_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vld_q        <= '0;
      ent_q        <= '0;
      vugid_q      <= '0;
      krr_q        <= '0;
      supp_q       <= 1'b0;
      supp_vugid_q <= '0;
      supp_krr_q   <= '0;
    end else begin
      state_q      <= state_d;
      vld_q        <= vld_d;
      ent_q        <= ent_d;
      vugid_q      <= vugid_d;
      krr_q        <= krr_d;
      supp_q       <= supp_d;
      supp_vugid_q <= supp_vugid_d;
      supp_krr_q   <= supp_krr_d;
    end
  end

  assign aclMissReq   = (state_q == S_MISS);
  assign aclBusy      = (state_q == S_MISS);
  assign aclMissVugid = vugid_q;
  assign aclMissKrr   = krr_q;
  assign aclEntryA    = vld_q[0] ? ent_q[0] : '0;
  assign aclEntryB    = vld_q[1] ? ent_q[1] : '0;
  assign aclEntryC    = vld_q[2] ? ent_q[2] : '0;
  assign aclEntryD    = vld_q[3] ? ent_q[3] : '0;
endmodule
